multdivid_seq_engine: RTL and testbench
=======================================

// Module: multdivid_seq_engine
// PURPOSE
//  Iterative multiply/divide datapath of the MultDivid unit. Reads the stored
//  34-bit divisor/multiplier operand and the rs operand when start is pulsed.
//  Runs a radix-2 shift-add multiply or restoring divide on magnitudes, then
//  writes a 64-bit result as hi/lo.
//  Sits between the divisor/multiplier register (input side) and the HI/LO
//  read path (output side).
// PARAMETERS
//  WIDTH   32  operand width; result is 2*WIDTH
//  DM_W    34  width of the stored divisor/multiplier value (WIDTH+2)
// PORTS
//  clk          in   1       rising-edge clock, single clock domain
//  reset        in   1       asynchronous, active-high; clears all state
//  start        in   1       1-cycle request; sampled only when not busy
//  op_div       in   1       1 = divide, 0 = multiply
//  op_signed    in   1       1 = two's-complement operands, 0 = unsigned
//  rs_value     in   WIDTH   multiplicand / dividend
//  dm_value     in   DM_W    stored divisor/multiplier; [31:0] operand, [33] sign extension
//  busy         out  1       iteration in progress
//  done         out  1       1-cycle pulse; hi/lo/div_by_zero valid from this cycle
//  hi           out  WIDTH   product[63:32] or remainder
//  lo           out  WIDTH   product[31:0] or quotient
//  div_by_zero  out  1       set with done when divide had dm_value[31:0]==0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0.
//  States: IDLE -> RUN -> FIX -> IDLE.
//  - IDLE: start=1 at edge E0 latches op_div, op_signed, rs_value and dm_value.
//    It also latches operand signs: signed uses rs_value[31] and dm_value[33];
//    unsigned uses 0 for both.
//    Magnitudes go into internal registers; iter count=0; go RUN; busy=1.
//  - RUN: one iteration per clock, edges E1..E32, then FIX.
//  - FIX, edge E33: conditional negation, then hi/lo load. done=1 and busy=0 in
//    the cycle after E33; state=IDLE.
//  Latency: done asserts 33 cycles after the start sample edge, for both ops.
//  start while busy=1 is ignored; no queuing. start in the done cycle is accepted.
//  dm_value and rs_value are don't-care after E0.
//  Multiply: 64-bit magnitude product.
//    Signed result is negated when sign_rs ^ sign_dm.
//    Result modulo 2^64 is exact for all inputs.
//  Divide: quotient magnitude goes to lo, remainder magnitude to hi.
//    Signed: quotient negated when sign_rs ^ sign_dm; remainder takes sign_rs.
//    -2^31 / -1 gives lo=32'h8000_0000, hi=0, no flag.
//  Divide by zero: iterations still run; latency unchanged.
//    FIX forces lo=32'hFFFF_FFFF, hi=rs_value as latched, div_by_zero=1.
//  div_by_zero is updated on every done: 0 for multiply and nonzero divide.
//  hi/lo/div_by_zero hold their value from done until the next FIX.
//  Reset during RUN/FIX aborts the operation: no done, and hi/lo return to 0.
// STRUCTURE
//  Package multdivid_pkg holds:
//    - WIDTH, DM_W
//    - state enum {IDLE, RUN, FIX}
//    - ITER_LAST = WIDTH-1
//    - OP_MUL/OP_DIV encodings
//  Sub-module multdivid_cond_negate (in WIDTH, neg -> out = neg ? -in : in),
//  with width as a parameter:
//    - instanced for operand magnitudes at capture
//    - instanced as 2*WIDTH for the product fix
//    - instanced for quotient and remainder fix
//  Single 64-bit accumulator/remainder register shared by both ops.
//  Iteration counter is 6 bits, one adder/subtractor of WIDTH+1 bits.
// TESTING
//  1. Unsigned mul rs=32'hFFFF_FFFF, dm=34'h0_FFFF_FFFF -> after 33 clk:
//     hi=FFFF_FFFE, lo=0000_0001, done=1 for one cycle.
//  2. Signed mul rs=-7 (FFFF_FFF9), dm=34'h3_FFFF_FFFD (-3) -> hi=0, lo=21.
//     Also rs=-7, dm=3 -> hi=FFFF_FFFF, lo=FFFF_FFEB.
//  3. Signed div rs=-7, dm=2 -> lo=FFFF_FFFD (-3), hi=FFFF_FFFF (-1).
//     Unsigned div 100/7 -> lo=14, hi=2.
//  4. Div by zero rs=1234, dm=0 -> done at 33, lo=FFFF_FFFF, hi=1234, div_by_zero=1.
//     A following mul clears div_by_zero.
//  5. Signed 8000_0000 / FFFF_FFFF -> lo=8000_0000, hi=0.
//     start pulsed at cycle 10 of a busy op is ignored; one done only.
//  6. Assert reset at cycle 15 of a divide -> busy, done, hi and lo go 0
//     immediately with no clock edge. A start after release completes normally.

Source files
------------

// File: rtl/multdivid_pkg.sv
// Shared constants and types for the MultDivid sequential engine.
package multdivid_pkg;

  localparam int WIDTH     = 32;
  localparam int DM_W      = WIDTH + 2;
  localparam int ITER_LAST = WIDTH - 1;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/multdivid_cond_negate.sv
// Two's-complement conditional negation used for magnitude capture and result fix-up.
module multdivid_cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? -a : a;

endmodule

// File: rtl/multdivid_seq_engine.sv
// Radix-2 shift-add multiply / restoring divide on magnitudes, 33 cycles start-to-done.
module multdivid_seq_engine
  import multdivid_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_div,
  input  logic              op_signed,
  input  logic [WIDTH-1:0]  rs_value,
  input  logic [DM_W-1:0]   dm_value,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              div_by_zero
);

  state_t               state;
  logic [5:0]           iter_cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     opnd;
  logic                 op_div_q;
  logic                 sign_rs;
  logic                 sign_dm;

  logic                 sign_rs_in;
  logic                 sign_dm_in;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     dm_mag;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH:0]       add_a;
  logic [WIDTH:0]       add_b;
  logic [WIDTH:0]       add_sum;
  logic                 unused_dm_bit;

  assign unused_dm_bit = dm_value[DM_W-2];

  assign sign_rs_in = op_signed & rs_value[WIDTH-1];
  assign sign_dm_in = op_signed & dm_value[DM_W-1];

  multdivid_cond_negate #(.W(WIDTH)) u_rs_mag (.a(rs_value), .neg(sign_rs_in), .y(rs_mag));
  multdivid_cond_negate #(.W(WIDTH)) u_dm_mag (.a(dm_value[WIDTH-1:0]), .neg(sign_dm_in), .y(dm_mag));

  multdivid_cond_negate #(.W(2*WIDTH)) u_prod_fix (.a(acc), .neg(sign_rs ^ sign_dm), .y(prod_fix));
  multdivid_cond_negate #(.W(WIDTH)) u_quo_fix (.a(acc[WIDTH-1:0]), .neg(sign_rs ^ sign_dm), .y(quo_fix));
  multdivid_cond_negate #(.W(WIDTH)) u_rem_fix (.a(acc[2*WIDTH-1:WIDTH]), .neg(sign_rs), .y(rem_fix));

  // Shared WIDTH+1 adder: adds the multiplicand to the upper half, or subtracts the
  // divisor from the left-shifted partial remainder (invert plus carry-in).
  assign add_a   = (op_div_q == OP_DIV) ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign add_b   = (op_div_q == OP_DIV) ? ~{1'b0, opnd} : {1'b0, opnd};
  assign add_sum = add_a + add_b + (WIDTH+1)'(op_div_q);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    acc_next = acc;
    if (op_div_q == OP_DIV) begin
      if (!add_sum[WIDTH]) acc_next = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                 acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_next = {add_sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      iter_cnt    <= '0;
      acc         <= '0;
      opnd        <= '0;
      op_div_q    <= OP_MUL;
      sign_rs     <= 1'b0;
      sign_dm     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div_q <= op_div;
            sign_rs  <= sign_rs_in;
            sign_dm  <= sign_dm_in;
            acc      <= {{WIDTH{1'b0}}, rs_mag};
            opnd     <= dm_mag;
            iter_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc      <= acc_next;
          iter_cnt <= iter_cnt + 6'd1;
          if (iter_cnt == 6'(ITER_LAST)) state <= FIX;
        end
        FIX: begin
          if (op_div_q == OP_DIV) begin
            // With a zero divisor the remainder path has shifted the dividend magnitude
            // back into the upper half, so rem_fix reproduces rs_value exactly.
            hi          <= rem_fix;
            lo          <= (opnd == '0) ? {WIDTH{1'b1}} : quo_fix;
            div_by_zero <= (opnd == '0);
          end else begin
            {hi, lo}    <= prod_fix;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdivid_seq_engine.sv
// Self-checking bench: arithmetic reference model, per-cycle compare, literal spot checks.
`timescale 1ns/1ps
module tb_multdivid_seq_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_div;
  logic        op_signed;
  logic [31:0] rs_value;
  logic [33:0] dm_value;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  multdivid_seq_engine dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div), .op_signed(op_signed),
    .rs_value(rs_value), .dm_value(dm_value), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values the spec defines.
  function automatic exp_t model(input logic d, input logic sg, input logic [31:0] rs,
                                 input logic [33:0] dm);
    exp_t        e;
    longint      a, b, r;
    logic [63:0] p;
    a = sg ? longint'($signed(rs)) : longint'({32'b0, rs});
    b = (sg && dm[33]) ? longint'({32'b0, dm[31:0]}) - 64'sh1_0000_0000
                       : longint'({32'b0, dm[31:0]});
    e.done_cyc = 0;
    if (!d) begin
      p    = a * b;
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
    end else if (dm[31:0] == 32'd0) begin
      e.hi = rs;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else begin
      r    = a / b;
      e.lo = r[31:0];
      r    = a % b;
      e.hi = r[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Acceptance model: a start is taken only when no operation is outstanding.
  always @(posedge clk) begin
    if (!reset) begin
      exp_t e;
      cyc++;
      if (start && q.size() == 0) begin
        e = model(op_div, op_signed, rs_value, dm_value);
        e.done_cyc = cyc + 33;
        q.push_back(e);
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      last.hi = '0; last.lo = '0; last.dz = 1'b0;
    end else begin
      logic done_exp;
      done_exp = (q.size() > 0) && (q[0].done_cyc == cyc);
      check("done", 64'(done), 64'(done_exp));
      if (done_exp) begin
        last = q[0];
        q.pop_front();
      end
      check("busy", 64'(busy), 64'(q.size() > 0));
      check("hi", 64'(hi), 64'(last.hi));
      check("lo", 64'(lo), 64'(last.lo));
      check("div_by_zero", 64'(div_by_zero), 64'(last.dz));
    end
  end

  task automatic run_op(input bit skip_wait, input int extra_at, input logic d, input logic sg,
                        input logic [31:0] rs, input logic [33:0] dm,
                        output logic [31:0] h, output logic [31:0] l, output logic z);
    int n;
    if (!skip_wait) @(negedge clk);
    start = 1'b1; op_div = d; op_signed = sg; rs_value = rs; dm_value = dm;
    @(negedge clk);
    start = 1'b0;
    rs_value = $urandom;
    dm_value = {2'($urandom), 32'($urandom)};
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      start = (n == extra_at);
      if (start) begin
        rs_value  = $urandom;
        op_div    = ~op_div;
        op_signed = ~op_signed;
      end
    end
    start = 1'b0;
    check("latency", 64'(n), 64'd33);
    h = hi; l = lo; z = div_by_zero;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, l;
    logic        z;
    reset = 1'b1; start = 1'b0; op_div = 1'b0; op_signed = 1'b0;
    rs_value = '0; dm_value = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, hi, lo, div_by_zero}, 67'd0);
    reset = 1'b0;

    run_op(0, -1, 1'b0, 1'b0, 32'hFFFF_FFFF, 34'h0_FFFF_FFFF, h, l, z);
    check("umul_max", {h, l}, 64'hFFFF_FFFE_0000_0001);
    check("umul_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("umul_done_low", 64'(done), 64'd0);

    run_op(0, -1, 1'b0, 1'b1, 32'hFFFF_FFF9, 34'h3_FFFF_FFFD, h, l, z);
    check("smul_neg_neg", {h, l}, 64'd21);
    run_op(0, -1, 1'b0, 1'b1, 32'hFFFF_FFF9, 34'h0_0000_0003, h, l, z);
    check("smul_neg_pos", {h, l}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(0, -1, 1'b1, 1'b1, 32'hFFFF_FFF9, 34'h0_0000_0002, h, l, z);
    check("sdiv_m7_2", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(0, -1, 1'b1, 1'b0, 32'd100, 34'd7, h, l, z);
    check("udiv_100_7", {h, l}, {32'd2, 32'd14});

    run_op(0, -1, 1'b1, 1'b0, 32'd1234, 34'd0, h, l, z);
    check("div0_result", {h, l}, {32'd1234, 32'hFFFF_FFFF});
    check("div0_flag", 64'(z), 64'd1);
    run_op(0, -1, 1'b0, 1'b0, 32'd3, 34'd5, h, l, z);
    check("mul_after_div0", {31'd0, z, h, l}, {32'd0, 32'd0, 32'd15});

    run_op(0, 10, 1'b1, 1'b1, 32'h8000_0000, 34'h3_FFFF_FFFF, h, l, z);
    check("sdiv_min_m1", {31'd0, z, h, l}, {32'd0, 32'd0, 32'h8000_0000});
    repeat (40) @(negedge clk);

    // Asynchronous abort of a divide mid-iteration.
    start = 1'b1; op_div = 1'b1; op_signed = 1'b0; rs_value = 32'd999; dm_value = 34'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", {busy, done, hi, lo, div_by_zero}, 67'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_op(0, -1, 1'b1, 1'b0, 32'd999, 34'd10, h, l, z);
    check("after_reset_div", {h, l}, {32'd9, 32'd99});

    for (int i = 0; i < 40; i++) begin
      logic        d, sg;
      logic [31:0] rs, dv;
      logic [1:0]  up;
      d  = 1'($urandom);
      sg = 1'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      dv = 32'($urandom);
      if (d && $urandom_range(0, 3) == 0) dv = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) dv = 32'hFFFF_FFFF;
      up = sg ? {2{dv[31]}} : 2'($urandom);
      run_op(($urandom_range(0, 2) == 0), -1, d, sg, rs, {up, dv}, h, l, z);
    end

    repeat (40) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
